// File: rtl/elevator_ctrl_if.sv
// Panel/login side <-> elevator car controller signal bundle.
interface elevator_ctrl_if #(
  parameter int FLOORS = 3
);
  localparam int FW = $clog2(FLOORS);

  logic              logged_in;
  logic [FLOORS-1:0] interior_panel;
  logic [FLOORS-1:0] exterior_panel;
  logic [1:0]        engine;
  logic [FLOORS-1:0] doors;
  logic [FW-1:0]     floor;
  logic              direction;
  logic [FLOORS-1:0] pending;

  // Panel/login logic drives calls and enable, observes car status
  modport master (
    output logged_in, interior_panel, exterior_panel,
    input  engine, doors, floor, direction, pending
  );

  // Car controller consumes calls and enable, drives car status
  modport slave (
    input  logged_in, interior_panel, exterior_panel,
    output engine, doors, floor, direction, pending
  );
endinterface

// File: rtl/elevator_ctrl.sv
// N-floor elevator car controller: latches calls, serves them in SCAN order,
// times floor-to-floor travel and door dwell with internal counters.
module elevator_ctrl #(
  parameter int FLOORS        = 3,
  parameter int DOOR_CYCLES   = 4,
  parameter int TRAVEL_CYCLES = 8
) (
  input logic            CLK,
  input logic            RST_N,
  elevator_ctrl_if.slave bus
);
  localparam int FW = $clog2(FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [FLOORS-1:0] pend_q, pend_d;
  logic [1:0]        engine_q, engine_d;
  logic [FLOORS-1:0] doors_q, doors_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [FLOORS-1:0] calls, clr;
  logic              ahead_up, ahead_dn;

  assign calls = bus.interior_panel | bus.exterior_panel;

  assign bus.engine    = engine_q;
  assign bus.doors     = doors_q;
  assign bus.floor     = floor_q;
  assign bus.direction = dir_q;
  assign bus.pending   = pend_q;

  // Outstanding calls strictly above / below the current floor
  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pend_q[i]) begin
        if (i > 32'(floor_q)) ahead_up = 1'b1;
        if (i < 32'(floor_q)) ahead_dn = 1'b1;
      end
    end
  end

  // SCAN next-state, output, timer and request-latch logic
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    engine_d = engine_q;
    doors_d  = doors_q;
    tcnt_d   = tcnt_q;
    dcnt_d   = dcnt_q;
    clr      = '0;
    if (bus.logged_in) begin
      case (state_q)
        IDLE: begin
          if (pend_q[floor_q]) begin
            state_d          = DOOR_OPEN;
            doors_d          = '0;
            doors_d[floor_q] = 1'b1;
            dcnt_d           = '0;
            clr[floor_q]     = 1'b1;
          end else if (dir_q ? ahead_up : ahead_dn) begin
            state_d  = MOVING;
            engine_d = dir_q ? 2'b10 : 2'b11;
            tcnt_d   = '0;
          end else if (dir_q ? ahead_dn : ahead_up) begin
            state_d  = MOVING;
            dir_d    = ~dir_q;
            engine_d = dir_q ? 2'b11 : 2'b10;
            tcnt_d   = '0;
          end
        end
        MOVING: begin
          if (tcnt_q == TW'(TRAVEL_CYCLES - 1)) begin
            floor_d = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
            tcnt_d  = '0;
            if (pend_q[floor_d]) begin
              state_d          = DOOR_OPEN;
              engine_d         = 2'b00;
              doors_d          = '0;
              doors_d[floor_d] = 1'b1;
              dcnt_d           = '0;
              clr[floor_d]     = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        DOOR_OPEN: begin
          if (calls[floor_q]) begin
            dcnt_d = '0;
          end else if (dcnt_q == DW'(DOOR_CYCLES - 1)) begin
            state_d = IDLE;
            doors_d = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // New calls win over the arrival clear, but a call for the floor whose
    // doors are already open is absorbed (it only extends the dwell).
    pend_d = (pend_q & ~clr) | calls;
    if (state_q == DOOR_OPEN) pend_d[floor_q] = 1'b0;
  end

  // State, outputs, timers and pending register; requests latch even when logged out
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      dir_q    <= 1'b1;
      pend_q   <= '0;
      engine_q <= 2'b00;
      doors_q  <= '0;
      tcnt_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      engine_q <= engine_d;
      doors_q  <= doors_d;
      tcnt_q   <= tcnt_d;
      dcnt_q   <= dcnt_d;
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl (FLOORS=4, DOOR_CYCLES=3, TRAVEL_CYCLES=2).
// Stimulus pushes expected output-change events; a monitor pops one whenever
// the observed {engine,doors,floor,direction,pending} changes (or a snapshot is
// requested) and checks it, including how many cycles the previous value lasted.
module tb_elevator_ctrl;
  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  elevator_ctrl_if #(.FLOORS(4)) bus ();

  elevator_ctrl #(
    .FLOORS(4),
    .DOOR_CYCLES(3),
    .TRAVEL_CYCLES(2)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [12:0] v;
    int          dur;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   compared  = 0;
  int   fails     = 0;
  int   snap_cnt  = 0;
  int   snap_seen = 0;

  function automatic logic [12:0] cur_snap();
    return {bus.engine, bus.doors, bus.floor, bus.direction, bus.pending};
  endfunction

  function automatic void push_ev(input logic [1:0] e, input logic [3:0] d,
                                  input logic [1:0] f, input logic r,
                                  input logic [3:0] p, input int dur,
                                  input string tag);
    exp_t x;
    x.v   = {e, d, f, r, p};
    x.dur = dur;
    x.tag = tag;
    q.push_back(x);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic drain(input int maxc, input string name);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      compared++;
      fails++;
      $display("FAIL %s timeout: %0d events still expected after %0d cycles, required 0",
               name, q.size(), maxc);
      q.delete();
    end
  endtask

  task automatic snap(input string tag);
    push_ev(2'b00, 4'b0000, 2'd0, 1'b1, 4'b0000, -1, tag);
    snap_cnt++;
  endtask

  // Assert reset mid-operation; outputs must clear without waiting for a clock
  task automatic do_reset(input string tag);
    logic [12:0] v;
    push_ev(2'b00, 4'b0000, 2'd0, 1'b1, 4'b0000, -1, tag);
    RST_N = 1'b0;
    #1;
    v = cur_snap();
    compared++;
    if (v !== 13'b00_0000_00_1_0000) begin
      fails++;
      $display("FAIL %s_immediate: got %b required %b", tag, v, 13'b00_0000_00_1_0000);
    end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  // Monitor: compare each observed output change against the scoreboard head
  initial begin
    logic [12:0] last, cur;
    int          run;
    bit          first;
    bit          changed;
    exp_t        x;
    first = 1'b1;
    run   = 0;
    last  = '0;
    forever begin
      @(negedge CLK);
      cur     = cur_snap();
      changed = (cur !== last);
      if (first) begin
        last  = cur;
        run   = 1;
        first = 1'b0;
      end else if (changed || snap_seen != snap_cnt) begin
        compared++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got %b, no event expected", cur);
        end else begin
          x = q.pop_front();
          if (cur !== x.v || (x.dur >= 0 && changed && run != x.dur)) begin
            fails++;
            $display("FAIL %s: got eng=%b doors=%b flr=%0d dir=%b pend=%b held=%0d, required eng=%b doors=%b flr=%0d dir=%b pend=%b held=%0d",
                     x.tag, cur[12:11], cur[10:7], cur[6:5], cur[4], cur[3:0], run,
                     x.v[12:11], x.v[10:7], x.v[6:5], x.v[4], x.v[3:0], x.dur);
          end
        end
        snap_seen = snap_cnt;
        if (changed) begin
          last = cur;
          run  = 1;
        end else begin
          run++;
        end
      end else begin
        run++;
      end
    end
  end

  // Stimulus: directed scenarios with hand-derived event sequences
  initial begin
    logic [12:0] v;
    bus.logged_in      = 1'b1;
    bus.interior_panel = '0;
    bus.exterior_panel = '0;

    // Reset state, then quiet for 10 cycles
    #1 RST_N = 1'b0;
    #2;
    v = cur_snap();
    compared++;
    if (v !== 13'b00_0000_00_1_0000) begin
      fails++;
      $display("FAIL reset_async: got %b required %b", v, 13'b00_0000_00_1_0000);
    end
    tick();
    tick();
    RST_N = 1'b1;
    snap("reset_state");
    repeat (10) tick();
    snap("reset_quiet10");
    drain(5, "reset");

    // Single trip 0 -> 3
    push_ev(2'b00, 4'b0000, 2'd0, 1'b1, 4'b1000, -1, "trip_latch");
    push_ev(2'b10, 4'b0000, 2'd0, 1'b1, 4'b1000,  1, "trip_start");
    push_ev(2'b10, 4'b0000, 2'd1, 1'b1, 4'b1000,  2, "trip_f1");
    push_ev(2'b10, 4'b0000, 2'd2, 1'b1, 4'b1000,  2, "trip_f2");
    push_ev(2'b00, 4'b1000, 2'd3, 1'b1, 4'b0000,  2, "trip_arrive3");
    push_ev(2'b00, 4'b0000, 2'd3, 1'b1, 4'b0000,  3, "trip_close");
    bus.interior_panel = 4'b1000;
    tick();
    bus.interior_panel = '0;
    drain(40, "trip");

    // SCAN ordering
    do_reset("scan_reset");
    push_ev(2'b00, 4'b0000, 2'd0, 1'b1, 4'b1000, -1, "scan_latch3");
    push_ev(2'b10, 4'b0000, 2'd0, 1'b1, 4'b1000,  1, "scan_go_up");
    push_ev(2'b10, 4'b0000, 2'd0, 1'b1, 4'b1011,  1, "scan_latch10");
    push_ev(2'b00, 4'b0010, 2'd1, 1'b1, 4'b1001,  1, "scan_stop1");
    push_ev(2'b00, 4'b0000, 2'd1, 1'b1, 4'b1001,  3, "scan_close1");
    push_ev(2'b10, 4'b0000, 2'd1, 1'b1, 4'b1001,  1, "scan_resume_up");
    push_ev(2'b10, 4'b0000, 2'd2, 1'b1, 4'b1001,  2, "scan_pass2");
    push_ev(2'b00, 4'b1000, 2'd3, 1'b1, 4'b0001,  2, "scan_stop3");
    push_ev(2'b00, 4'b0000, 2'd3, 1'b1, 4'b0001,  3, "scan_close3");
    push_ev(2'b11, 4'b0000, 2'd3, 1'b0, 4'b0001,  1, "scan_reverse");
    push_ev(2'b11, 4'b0000, 2'd2, 1'b0, 4'b0001,  2, "scan_down2");
    push_ev(2'b11, 4'b0000, 2'd1, 1'b0, 4'b0001,  2, "scan_down1");
    push_ev(2'b00, 4'b0001, 2'd0, 1'b0, 4'b0000,  2, "scan_stop0");
    push_ev(2'b00, 4'b0000, 2'd0, 1'b0, 4'b0000,  3, "scan_close0");
    bus.interior_panel = 4'b1000;
    tick();
    bus.interior_panel = '0;
    tick();
    bus.exterior_panel = 4'b0010;
    bus.interior_panel = 4'b0001;
    tick();
    bus.exterior_panel = '0;
    bus.interior_panel = '0;
    drain(60, "scan");

    // Door hold at floor 2 (starting at floor 0 heading down)
    push_ev(2'b00, 4'b0000, 2'd0, 1'b0, 4'b0100, -1, "hold_latch2");
    push_ev(2'b10, 4'b0000, 2'd0, 1'b1, 4'b0100,  1, "hold_turn_up");
    push_ev(2'b10, 4'b0000, 2'd1, 1'b1, 4'b0100,  2, "hold_pass1");
    push_ev(2'b00, 4'b0100, 2'd2, 1'b1, 4'b0000,  2, "hold_open2");
    push_ev(2'b00, 4'b0000, 2'd2, 1'b1, 4'b0000,  4, "hold_close_extended");
    bus.interior_panel = 4'b0100;
    tick();
    bus.interior_panel = '0;
    repeat (5) tick();
    bus.interior_panel = 4'b0100;
    tick();
    bus.interior_panel = '0;
    drain(40, "hold");

    // Login gating mid-travel, then reset while moving down at floor 2
    do_reset("gate_reset");
    push_ev(2'b00, 4'b0000, 2'd0, 1'b1, 4'b1000, -1, "gate_latch3");
    push_ev(2'b10, 4'b0000, 2'd0, 1'b1, 4'b1000,  1, "gate_go_up");
    push_ev(2'b10, 4'b0000, 2'd1, 1'b1, 4'b1000,  2, "gate_f1");
    push_ev(2'b10, 4'b0000, 2'd1, 1'b1, 4'b1001,  2, "gate_latch0_frozen");
    push_ev(2'b10, 4'b0000, 2'd2, 1'b1, 4'b1001,  5, "gate_resume_f2");
    push_ev(2'b00, 4'b1000, 2'd3, 1'b1, 4'b0001,  2, "gate_stop3");
    push_ev(2'b00, 4'b0000, 2'd3, 1'b1, 4'b0001,  3, "gate_close3");
    push_ev(2'b11, 4'b0000, 2'd3, 1'b0, 4'b0001,  1, "gate_reverse");
    push_ev(2'b11, 4'b0000, 2'd2, 1'b0, 4'b0001,  2, "gate_down2");
    bus.interior_panel = 4'b1000;
    tick();
    bus.interior_panel = '0;
    repeat (3) tick();
    bus.logged_in = 1'b0;
    tick();
    bus.exterior_panel = 4'b0001;
    tick();
    bus.exterior_panel = '0;
    repeat (3) tick();
    bus.logged_in = 1'b1;
    repeat (11) tick();
    do_reset("midmove_reset");
    drain(10, "midmove");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

  // Global run-time guard
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
